// File: rtl/priority_encoder_16x4_pkg.sv
// Shared types and helpers for the 16-to-4 priority encoder.
// Holds the width constants, request/index typedefs and the 4x2 leaf encoder.
package pe_pkg;

   localparam int IN_W  = 16;
   localparam int OUT_W = 4;
   localparam int GRP_W = 4;
   localparam int NUM_GRP = IN_W / GRP_W;

   typedef logic [IN_W-1:0]  req_t;
   typedef logic [OUT_W-1:0] idx_t;

   // Leaf 4x2 priority encoder, written as plain boolean equations so that
   // X on any input reaches the output instead of being absorbed by a case.
   function automatic logic [1:0] enc4(input logic [3:0] v);
      logic [1:0] r;
      r[1] = v[3] | v[2];
      r[0] = v[3] | (~v[2] & v[1]);
      return r;
   endfunction

endpackage

// File: rtl/priority_encoder_16x4_comb.sv
// Combinational core: two-level tree of 4x2 priority encoders.
// The upper level picks the highest non-empty nibble, the lower level encodes inside it.
module priority_encoder_16x4_comb
   import pe_pkg::*;
(
   input  logic             en,
   input  logic [IN_W-1:0]  i,
   output logic [OUT_W-1:0] next_y,
   output logic             next_valid
);

   logic [NUM_GRP-1:0]                grp_any;
   logic [NUM_GRP-1:0][GRP_W-1:0]     grp_req;
   logic [NUM_GRP-1:0][GRP_W-1:0]     grp_masked;
   logic [1:0]                        hi_idx;
   logic [1:0]                        lo_idx;
   logic [GRP_W-1:0]                  sel_nib;

   genvar g;
   generate
      for (g = 0; g < NUM_GRP; g++) begin : g_grp
         assign grp_req[g]    = i[g*GRP_W +: GRP_W];
         assign grp_any[g]    = |grp_req[g];
         // AND-OR select keeps X on hi_idx visible in the selected nibble
         assign grp_masked[g] = grp_req[g] & {GRP_W{hi_idx == 2'(g)}};
      end
   endgenerate

   assign hi_idx = enc4(grp_any);

   always_comb begin
      sel_nib = '0;
      for (int k = 0; k < NUM_GRP; k++) begin
         sel_nib = sel_nib | grp_masked[k];
      end
   end

   assign lo_idx     = enc4(sel_nib);
   assign next_y     = {hi_idx, lo_idx} & {OUT_W{en}};
   assign next_valid = en & (|i);

endmodule

// File: rtl/priority_encoder_16x4.sv
// Registered 16-to-4 priority encoder with enable; y/valid come straight from flops.
// One cycle latency, new encode every cycle, async active-low clear.
module priority_encoder_16x4
   import pe_pkg::*;
#(
   parameter int IN_W_P  = IN_W,
   parameter int OUT_W_P = OUT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [IN_W_P-1:0]  i,
   output logic [OUT_W_P-1:0] y,
   output logic               valid
);

   idx_t next_y;
   logic next_valid;
   idx_t y_d, y_q;
   logic valid_d, valid_q;

   priority_encoder_16x4_comb u_comb (
      .en         (en),
      .i          (req_t'(i)),
      .next_y     (next_y),
      .next_valid (next_valid)
   );

   always_comb begin
      y_d     = next_y;
      valid_d = next_valid;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         y_q     <= y_d;
         valid_q <= valid_d;
      end
   end

   assign y     = OUT_W_P'(y_q);
   assign valid = valid_q;

endmodule

// File: tb/tb_priority_encoder_16x4.sv
// Self-checking bench: directed plan plus random vectors against a scan-based model.
module tb_priority_encoder_16x4;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [15:0] i;
   logic [3:0]  y;
   logic        valid;

   int          n_chk;
   int          n_err;
   logic [3:0]  exp_y;
   logic        exp_v;

   priority_encoder_16x4 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .i     (i),
      .y     (y),
      .valid (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference: highest set index by plain scan of the request word.
   function automatic logic [3:0] model_y(input bit e, input logic [15:0] v);
      if (!e || v == 16'h0) return 4'd0;
      for (int k = 15; k >= 0; k--) begin
         if (v[k]) return 4'(k);
      end
      return 4'd0;
   endfunction

   // Drive at negedge, confirm outputs did not move combinationally,
   // then check the registered result just after the next rising edge.
   task automatic step(input bit e, input logic [15:0] v, input string tag);
      @(negedge clk);
      en = e;
      i  = v;
      #1;
      chk({tag, "_hold_y"}, 32'(y), 32'(exp_y));
      chk({tag, "_hold_v"}, 32'(valid), 32'(exp_v));
      exp_y = model_y(e, v);
      exp_v = e && (v != 16'h0);
      @(posedge clk);
      #1;
      chk({tag, "_y"}, 32'(y), 32'(exp_y));
      chk({tag, "_v"}, 32'(valid), 32'(exp_v));
   endtask

   initial begin
      logic [15:0] r;
      n_chk = 0;
      n_err = 0;
      en    = 1'b0;
      i     = 16'h0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_y", 32'(y), 32'd0);
      chk("reset_v", 32'(valid), 32'd0);
      exp_y = 4'd0;
      exp_v = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 15; k >= 1; k--) step(1'b1, 16'h1 << k, "walk");
      step(1'b1, 16'h0000, "zero");
      step(1'b1, 16'h0001, "lsb");
      step(1'b1, 16'hFFFF, "prio_ffff");
      step(1'b1, 16'h8001, "prio_8001");
      step(1'b1, 16'h00F0, "prio_00f0");
      step(1'b1, 16'h0A00, "prio_0a00");
      step(1'b0, 16'h8000, "dis");
      step(1'b0, 16'hFFFF, "dis_ffff");
      step(1'b1, 16'h8000, "reen");

      // Async reset mid-cycle while y=15, valid=1
      @(posedge clk);
      #3;
      chk("pre_rst_y", 32'(y), 32'd15);
      rst_n = 1'b0;
      #1;
      chk("async_rst_y", 32'(y), 32'd0);
      chk("async_rst_v", 32'(valid), 32'd0);
      @(negedge clk);
      en    = 1'b1;
      i     = 16'h0010;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_y", 32'(y), 32'd4);
      chk("post_rst_v", 32'(valid), 32'd1);
      exp_y = 4'd4;
      exp_v = 1'b1;

      step(1'b1, 16'h0004, "b2b0");
      step(1'b1, 16'h2000, "b2b1");
      step(1'b1, 16'h0000, "b2b2");
      step(1'b1, 16'h0100, "b2b3");

      for (int n = 0; n < 300; n++) begin
         r = 16'($urandom);
         // Thin out bits so that low-index winners appear often
         case ($urandom_range(0, 3))
            0: r = r & 16'($urandom);
            1: r = r & 16'($urandom) & 16'($urandom) & 16'($urandom);
            2: r = r >> $urandom_range(0, 15);
            default: ;
         endcase
         step(($urandom_range(0, 7) != 0), r, "rand");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
